// File: rtl/dsdctl_pkg.sv
// dsdctl_pkg: shared constants for the DSD TDM lock controller.
// Holds the state encoding, the default parameter values, the flywheel event
// codes and a small state-decode helper.
package dsdctl_pkg;

   // Default parameter values
   localparam int unsigned FRAME_LEN_DEF        = 32;
   localparam int unsigned LOCK_FRAMES_DEF      = 4;
   localparam int unsigned UNLOCK_MISSES_DEF    = 2;
   localparam int unsigned MUTE_HOLD_FRAMES_DEF = 8;
   localparam int unsigned CNT_W_DEF            = 8;

   // Controller state encoding
   localparam logic [1:0] ST_UNLOCK = 2'd0;
   localparam logic [1:0] ST_ACQ    = 2'd1;
   localparam logic [1:0] ST_LOCK   = 2'd2;
   localparam logic [1:0] ST_PROT   = 2'd3;

   // Flywheel event codes; at most one event per cycle
   localparam logic [1:0] EV_NONE  = 2'd0;
   localparam logic [1:0] EV_GOOD  = 2'd1;
   localparam logic [1:0] EV_MISS  = 2'd2;
   localparam logic [1:0] EV_EARLY = 2'd3;

   // True for the states in which the frame is considered locked
   function automatic logic st_locked(input logic [1:0] st);
      return (st == ST_LOCK) || (st == ST_PROT);
   endfunction

endpackage

// File: rtl/dsd_frame_flywheel.sv
// dsd_frame_flywheel: free-running frame position counter with FrameSync
// classification.
// Ports:
//   in_BCK    in   bit clock, rising edge
//   in_Reset  in   synchronous active-high reset
//   FrameSync in   frame marker, high on the last bit of a frame
//   ev_c      out  combinational event code for the current cycle
//                  (EV_GOOD / EV_MISS on the boundary, EV_EARLY off it)
module dsd_frame_flywheel
   import dsdctl_pkg::*;
#(
   parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
)(
   input  logic       in_BCK,
   input  logic       in_Reset,
   input  logic       FrameSync,
   output logic [1:0] ev_c
);

   localparam int unsigned FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [FCW-1:0] LAST_POS = FCW'(FRAME_LEN - 1);

   logic [FCW-1:0] frame_cnt;
   logic           boundary_c;

   assign boundary_c = (frame_cnt == LAST_POS);

   // Wrap at the boundary; any sync realigns so the next cycle is position 0
   always_ff @(posedge in_BCK) begin
      if (in_Reset)
         frame_cnt <= '0;
      else if (boundary_c || FrameSync)
         frame_cnt <= '0;
      else
         frame_cnt <= frame_cnt + FCW'(1);
   end

   // Event classification
   always_comb begin
      ev_c = EV_NONE;
      if (boundary_c)
         ev_c = FrameSync ? EV_GOOD : EV_MISS;
      else if (FrameSync)
         ev_c = EV_EARLY;
   end

endmodule

// File: rtl/dsd_tdm_lock_ctrl.sv
// dsd_tdm_lock_ctrl: frame lock / protection sequencer for the DSD TDM divider.
// Tracks FrameSync through a flywheel, gates the divider's Protect_EN, mutes
// until locked and holds the mute for a number of clean frames after a
// protection event.
// Ports:
//   in_BCK        in   bit clock, rising edge
//   in_Reset      in   synchronous active-high reset
//   FrameSync     in   frame marker (last bit of a frame)
//   ProtectFlag   in   divider full-scale detect, valid on boundary cycles
//   Protect_Req   in   host protection enable request
//   ErrClear      in   clears ErrCount and ProtectSticky
//   Protect_EN    out  protection enable to the divider
//   Mute          out  downstream mute
//   Locked        out  frame lock status
//   ErrCount      out  saturating error counter
//   ProtectSticky out  sticky protection-event flag
// Build option: DSDCTL_PROTECT_STICKY_EN enables the ProtectSticky register;
// without it ProtectSticky is tied low.
module dsd_tdm_lock_ctrl
   import dsdctl_pkg::*;
#(
   parameter int unsigned FRAME_LEN        = FRAME_LEN_DEF,
   parameter int unsigned LOCK_FRAMES      = LOCK_FRAMES_DEF,
   parameter int unsigned UNLOCK_MISSES    = UNLOCK_MISSES_DEF,
   parameter int unsigned MUTE_HOLD_FRAMES = MUTE_HOLD_FRAMES_DEF,
   parameter int unsigned CNT_W            = CNT_W_DEF
)(
   input  logic             in_BCK,
   input  logic             in_Reset,
   input  logic             FrameSync,
   input  logic             ProtectFlag,
   input  logic             Protect_Req,
   input  logic             ErrClear,
   output logic             Protect_EN,
   output logic             Mute,
   output logic             Locked,
   output logic [CNT_W-1:0] ErrCount,
   output logic             ProtectSticky
);

   localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);
   localparam int unsigned MW = $clog2(UNLOCK_MISSES + 1);
   localparam int unsigned HW = $clog2(MUTE_HOLD_FRAMES + 1);

   logic [1:0]    ev_c;
   logic [1:0]    state, state_nxt;
   logic [GW-1:0] good_cnt, good_nxt;
   logic [MW-1:0] miss_cnt, miss_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic          err_c;
   logic          prot_entry_c;

   dsd_frame_flywheel #(
      .FRAME_LEN (FRAME_LEN)
   ) u_flywheel (
      .in_BCK    (in_BCK),
      .in_Reset  (in_Reset),
      .FrameSync (FrameSync),
      .ev_c      (ev_c)
   );

   // State register
   always_ff @(posedge in_BCK) begin
      if (in_Reset)
         state <= ST_UNLOCK;
      else
         state <= state_nxt;
   end

   // Next-state and counter update; unlock beats protect entry beats hold countdown
   always_comb begin
      state_nxt    = state;
      good_nxt     = good_cnt;
      miss_nxt     = miss_cnt;
      hold_nxt     = hold_cnt;
      err_c        = 1'b0;
      prot_entry_c = 1'b0;

      case (state)
         ST_UNLOCK: begin
            if (FrameSync)
               state_nxt = ST_ACQ;
         end
         ST_ACQ: begin
            case (ev_c)
               EV_GOOD: begin
                  if (good_cnt == GW'(LOCK_FRAMES - 1))
                     state_nxt = ST_LOCK;
                  else
                     good_nxt = good_cnt + GW'(1);
               end
               EV_MISS:  state_nxt = ST_UNLOCK;
               EV_EARLY: begin
                  good_nxt = '0;
                  err_c    = 1'b1;
               end
               default: ;
            endcase
         end
         ST_LOCK, ST_PROT: begin
            if ((ev_c == EV_MISS) || (ev_c == EV_EARLY)) begin
               err_c = 1'b1;
               if (miss_cnt == MW'(UNLOCK_MISSES - 1))
                  state_nxt = ST_UNLOCK;
               else
                  miss_nxt = miss_cnt + MW'(1);
            end else if (ev_c == EV_GOOD) begin
               miss_nxt = '0;
            end

            if (state_nxt != ST_UNLOCK) begin
               if (state == ST_LOCK) begin
                  if ((ev_c == EV_GOOD) && ProtectFlag && Protect_EN) begin
                     state_nxt    = ST_PROT;
                     hold_nxt     = HW'(MUTE_HOLD_FRAMES);
                     prot_entry_c = 1'b1;
                     err_c        = 1'b1;
                  end
               end else if ((ev_c == EV_GOOD) || (ev_c == EV_MISS)) begin
                  // Hold countdown runs once per frame boundary
                  if (ProtectFlag)
                     hold_nxt = HW'(MUTE_HOLD_FRAMES);
                  else if (hold_cnt <= HW'(1)) begin
                     hold_nxt  = '0;
                     state_nxt = ST_LOCK;
                  end else
                     hold_nxt = hold_cnt - HW'(1);
               end
            end
         end
         default: state_nxt = ST_UNLOCK;
      endcase

      if (state_nxt != state) begin
         good_nxt = '0;
         miss_nxt = '0;
      end
   end

   // Counters and registered outputs, decoded from the next state
   always_ff @(posedge in_BCK) begin
      if (in_Reset) begin
         good_cnt   <= '0;
         miss_cnt   <= '0;
         hold_cnt   <= '0;
         ErrCount   <= '0;
         Protect_EN <= 1'b0;
         Mute       <= 1'b1;
         Locked     <= 1'b0;
      end else begin
         good_cnt   <= good_nxt;
         miss_cnt   <= miss_nxt;
         hold_cnt   <= hold_nxt;
         Protect_EN <= Protect_Req && st_locked(state_nxt);
         Mute       <= (state_nxt != ST_LOCK);
         Locked     <= st_locked(state_nxt);
         if (ErrClear)
            ErrCount <= '0;
         else if (err_c && (ErrCount != {CNT_W{1'b1}}))
            ErrCount <= ErrCount + CNT_W'(1);
      end
   end

`ifdef DSDCTL_PROTECT_STICKY_EN
   logic sticky;

   // Set on every protection entry; set beats a simultaneous clear
   always_ff @(posedge in_BCK) begin
      if (in_Reset)
         sticky <= 1'b0;
      else if (prot_entry_c)
         sticky <= 1'b1;
      else if (ErrClear)
         sticky <= 1'b0;
   end

   assign ProtectSticky = sticky;
`else
   assign ProtectSticky = 1'b0;
`endif

endmodule
